// File: rtl/clk_bus_gen.sv
// clk_bus_gen: bus of NUM_CLKS divided clocks from a single clock.
// Each channel has a programmable half-period. A valid/ready config port
// retunes one channel at a time. The new divisor is loaded only at a point
// where that channel would have risen, so no short high pulse is produced.
module clk_bus_gen #(
  parameter int NUM_CLKS = 4,
  parameter int DIV_W    = 8,
  parameter int DEF_DIV  = 2,
  localparam int IDX_W   = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [IDX_W-1:0]    i_cfg_idx,
  input  logic [DIV_W-1:0]    i_cfg_div,
  output logic [NUM_CLKS-1:0] o_clks,
  output logic [NUM_CLKS-1:0] o_rise,
  output logic                o_busy
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_APPLY} state_t;

  state_t              state_q;
  logic                ready_q;
  logic                busy_q;
  logic [IDX_W-1:0]    cfg_idx_q;
  logic [DIV_W-1:0]    cfg_div_q;

  logic [DIV_W-1:0]    div_q [NUM_CLKS];
  logic [DIV_W-1:0]    div_d [NUM_CLKS];
  logic [DIV_W-1:0]    cnt_q [NUM_CLKS];
  logic [DIV_W-1:0]    cnt_d [NUM_CLKS];
  logic [NUM_CLKS-1:0] clk_q;
  logic [NUM_CLKS-1:0] clk_d;
  logic [NUM_CLKS-1:0] rise_q;

  logic [31:0]         idx_ext;
  logic                idx_ok;
  logic [DIV_W-1:0]    sel_div;
  logic [DIV_W-1:0]    sel_cnt;
  logic                sel_clk;
  logic                apply;

  // Range check is done at 32 bits so non-power-of-two channel counts
  // can reject indices the port width can still express.
  assign idx_ext = 32'(i_cfg_idx);
  assign idx_ok  = (idx_ext < 32'(NUM_CLKS));

  // State of the channel being retuned
  always_comb begin
    sel_div = div_q[cfg_idx_q];
    sel_cnt = cnt_q[cfg_idx_q];
    sel_clk = clk_q[cfg_idx_q];
  end

  // Apply when the target would rise next edge, or immediately if it is not running
  assign apply = (state_q == S_WAIT) &&
                 (!i_enable || (sel_div == '0) ||
                  (!sel_clk && (sel_cnt == sel_div - DIV_ONE)));

  // Per-channel divider next state, with the retune overriding its target
  always_comb begin
    for (int unsigned n = 0; n < NUM_CLKS; n++) begin
      div_d[n] = div_q[n];
      cnt_d[n] = cnt_q[n];
      clk_d[n] = clk_q[n];
      if (!i_enable || (div_q[n] == '0)) begin
        cnt_d[n] = '0;
        clk_d[n] = 1'b0;
      end else if (cnt_q[n] == div_q[n] - DIV_ONE) begin
        cnt_d[n] = '0;
        clk_d[n] = ~clk_q[n];
      end else begin
        cnt_d[n] = cnt_q[n] + DIV_ONE;
      end
      if (apply && (cfg_idx_q == IDX_W'(n))) begin
        div_d[n] = cfg_div_q;
        cnt_d[n] = '0;
        clk_d[n] = 1'b0;
      end
    end
  end

  // Channel registers and rise pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned n = 0; n < NUM_CLKS; n++) begin
        div_q[n] <= DIV_RST;
        cnt_q[n] <= '0;
      end
      clk_q  <= '0;
      rise_q <= '0;
    end else begin
      for (int unsigned n = 0; n < NUM_CLKS; n++) begin
        div_q[n] <= div_d[n];
        cnt_q[n] <= cnt_d[n];
      end
      clk_q  <= clk_d;
      rise_q <= clk_d & ~clk_q;
    end
  end

  // Config FSM with registered ready/busy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      cfg_idx_q <= '0;
      cfg_div_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_cfg_valid && ready_q && idx_ok) begin
            cfg_idx_q <= i_cfg_idx;
            cfg_div_q <= i_cfg_div;
            state_q   <= S_WAIT;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (apply) begin
            state_q <= S_APPLY;
          end
        end
        S_APPLY: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_clks      = clk_q;
  assign o_rise      = rise_q;
  assign o_cfg_ready = ready_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_clk_bus_gen.sv
// Testbench for clk_bus_gen: per-cycle comparison against a phase-count model.
// Five channels are used so that indices 5..7 are out of range on a 3-bit port.
module tb_clk_bus_gen;

  localparam int NC = 5;
  localparam int DW = 8;
  localparam int DD = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          valid;
  logic [IW-1:0] idx;
  logic [DW-1:0] dv;
  logic          ready;
  logic          busy;
  logic [NC-1:0] clks;
  logic [NC-1:0] rise;

  int tests = 0;
  int fails = 0;

  // Model: per channel, ticks since (re)start; output high on odd half-periods
  int            m_div [NC];
  int            m_k   [NC];
  logic [NC-1:0] m_clk;
  logic [NC-1:0] m_rise;
  int            m_state;  // 0 idle, 1 waiting for rise point, 2 apply
  int            m_idx;
  int            m_ndiv;

  clk_bus_gen #(.NUM_CLKS(NC), .DIV_W(DW), .DEF_DIV(DD)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (en),
    .i_cfg_valid (valid),
    .o_cfg_ready (ready),
    .i_cfg_idx   (idx),
    .i_cfg_div   (dv),
    .o_clks      (clks),
    .o_rise      (rise),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*NC+1:0] expv();
    return {m_clk, m_rise, (m_state == 0), (m_state != 0)};
  endfunction

  function automatic logic [2*NC+1:0] obsv();
    return {clks, rise, ready, busy};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_div[i] = DD;
      m_k[i]   = 0;
    end
    m_clk   = '0;
    m_rise  = '0;
    m_state = 0;
    m_idx   = 0;
    m_ndiv  = 0;
  endtask

  function automatic bit rise_due(int n);
    if (!en || m_div[n] == 0) return 1'b0;
    return (((m_k[n] + 1) % m_div[n]) == 0) && ((((m_k[n] + 1) / m_div[n]) % 2) == 1);
  endfunction

  task automatic model_edge();
    logic [NC-1:0] nclk;
    bit            app;
    if (rst) return;
    app = (m_state == 1) && (!en || m_div[m_idx] == 0 || rise_due(m_idx));
    for (int n = 0; n < NC; n++) begin
      if (!en || m_div[n] == 0) begin
        m_k[n]  = 0;
        nclk[n] = 1'b0;
      end else begin
        m_k[n]  = (m_k[n] + 1) % (2 * m_div[n]);
        nclk[n] = ((m_k[n] / m_div[n]) % 2) == 1;
      end
    end
    if (app) begin
      m_div[m_idx] = m_ndiv;
      m_k[m_idx]   = 0;
      nclk[m_idx]  = 1'b0;
    end
    m_rise = nclk & ~m_clk;
    m_clk  = nclk;
    case (m_state)
      0: if (valid && (int'(idx) < NC)) begin
           m_idx   = int'(idx);
           m_ndiv  = int'(dv);
           m_state = 1;
         end
      1: if (app) m_state = 2;
      default: m_state = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; valid = 1'b0; idx = '0; dv = '0;
    #3;
    model_reset();
    tests++;
    if (obsv() !== 12'b0000000000_10) begin
      fails++; $display("FAIL reset_async got=%b want=%b", obsv(), 12'b0000000000_10);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL reset_hold cyc=%0d got=%b want=%b", c, obsv(), expv());
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      tests++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL basic cyc=%0d got=%b want=%b", c, obsv(), expv());
      end
      if (c == 2 || c == 6 || c == 10) begin
        tests++;
        if (clks !== 5'b11111 || rise !== 5'b11111) begin
          fails++; $display("FAIL basic_rise edge=%0d clks=%b rise=%b want 11111/11111", c, clks, rise);
        end
      end
      if (c == 4) begin
        tests++;
        if (clks !== 5'b00000) begin
          fails++; $display("FAIL basic_low edge=4 clks=%b want 00000", clks);
        end
      end
    end
  endtask

  task automatic test_retune(input logic [IW-1:0] ti, input logic [DW-1:0] td, input int settle);
    bit done;
    valid = 1'b1; idx = ti; dv = td;
    tick();
    valid = 1'b0;
    tests++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL retune_accept idx=%0d ready=%b busy=%b want 0/1", ti, ready, busy);
    end
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      tick();
      tests++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL retune_wait idx=%0d cyc=%0d got=%b want=%b", ti, c, obsv(), expv());
      end
      if (ready === 1'b1) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++; $display("FAIL retune_timeout idx=%0d ready=%b want 1", ti, ready);
    end
    for (int c = 0; c < settle; c++) begin
      tick();
      tests++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL retune_run idx=%0d div=%0d cyc=%0d got=%b want=%b", ti, td, c, obsv(), expv());
      end
    end
  endtask

  task automatic test_bad_idx();
    for (int i = 5; i <= 7; i++) begin
      valid = 1'b1; idx = IW'(i); dv = 8'd1;
      tick();
      valid = 1'b0;
      tests++;
      if (busy !== 1'b0 || ready !== 1'b1) begin
        fails++; $display("FAIL bad_idx idx=%0d busy=%b ready=%b want 0/1", i, busy, ready);
      end
      for (int c = 0; c < 6; c++) begin
        tick();
        tests++;
        if (obsv() !== expv()) begin
          fails++; $display("FAIL bad_idx_run idx=%0d cyc=%0d got=%b want=%b", i, c, obsv(), expv());
        end
      end
    end
  endtask

  task automatic test_enable();
    bit hi;
    hi = 1'b0;
    for (int c = 0; c < 8 && !hi; c++) begin
      tick();
      if (clks[0] === 1'b1) hi = 1'b1;
    end
    tests++;
    if (!hi) begin
      fails++; $display("FAIL en_find_high clks=%b want ch0 high", clks);
    end
    en = 1'b0;
    tick();
    tests++;
    if (clks !== 5'b00000 || rise !== 5'b00000) begin
      fails++; $display("FAIL en_drop clks=%b rise=%b want 00000", clks, rise);
    end
    en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      tests++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL en_resume cyc=%0d got=%b want=%b", c, obsv(), expv());
      end
    end
    valid = 1'b1; idx = 3'd3; dv = 8'd4;
    tick();
    valid = 1'b0;
    en = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      fails++; $display("FAIL en_wait_apply busy=%b ready=%b want 1/0", busy, ready);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || ready !== 1'b1 || clks !== 5'b00000) begin
      fails++; $display("FAIL en_wait_idle busy=%b ready=%b clks=%b want 0/1/00000", busy, ready, clks);
    end
    en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      tests++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL en_after_cfg cyc=%0d got=%b want=%b", c, obsv(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 39) != 0);
      valid = ($urandom_range(0, 3) == 0);
      idx   = IW'($urandom_range(0, 7));
      dv    = ($urandom_range(0, 15) == 0) ? 8'd255 : DW'($urandom_range(0, 6));
      tick();
      tests++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL random cyc=%0d got=%b want=%b", c, obsv(), expv());
      end
    end
    valid = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 8; c++) tick();
    valid = 1'b1; idx = 3'd0; dv = 8'd5;
    tick();
    valid = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL arst_in_wait busy=%b want 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    tests++;
    if (obsv() !== 12'b0000000000_10) begin
      fails++; $display("FAIL arst_now got=%b want=%b", obsv(), 12'b0000000000_10);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      tests++;
      if (obsv() !== expv()) begin
        fails++; $display("FAIL arst_after cyc=%0d got=%b want=%b", c, obsv(), expv());
      end
      if (c == 2) begin
        tests++;
        if (clks !== 5'b11111) begin
          fails++; $display("FAIL arst_defdiv clks=%b want 11111", clks);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retune(3'd1, 8'd3, 20);
    test_retune(3'd2, 8'd0, 10);
    test_retune(3'd2, 8'd1, 10);
    test_bad_idx();
    test_enable();
    test_retune(3'd4, 8'd255, 520);
    test_retune(3'd4, 8'd2, 10);
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
